// File: rtl/pipe_reg_hs.sv
// -----------------------------------------------------------------------------
// pipe_reg_hs -- multi-stage valid/ready pipeline register with bubble collapse
//
// A chain of STAGES registers, each holding one valid bit and one WIDTH-bit
// data word. Stage 0 faces the input and stage STAGES-1 drives the output.
// A word moves forward whenever the next stage is empty or is itself moving
// forward, so bubbles collapse even while the downstream side is stalled.
// The ready path from out_ready to in_ready is purely combinational.
//
// Ports
//   clk        clock, rising edge
//   reset      synchronous, active-high; clears valids, loads RST_VAL, count=0
//   flush      synchronous discard of all held words; blocks both transfers
//   in_valid   upstream presents in_data
//   in_ready   stage 0 can take a word this cycle
//   in_data    upstream payload (WIDTH bits)
//   out_valid  last stage holds a word (forced low during flush)
//   out_ready  downstream accepts out_data
//   out_data   payload of the last stage
//   count      number of occupied stages, registered
// -----------------------------------------------------------------------------
module pipe_reg_hs #(
    parameter int               WIDTH   = 8,
    parameter int               STAGES  = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             flush,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WIDTH-1:0]                 in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [WIDTH-1:0]                 out_data,
    output logic [$clog2(STAGES+1)-1:0]      count
);

    localparam int CW = $clog2(STAGES+1);

    logic [STAGES-1:0]            valid;
    logic [STAGES-1:0][WIDTH-1:0] data;

    // cap[k]: stage k can take a new word this cycle (it is empty, or its
    // current word is leaving). Stage k loads from stage k-1 exactly when
    // cap[k] is set; cap[k] implies cap[k-1], so the source is leaving too.
    logic [STAGES-1:0]            cap;
    logic [STAGES-1:0]            vin;
    logic [STAGES-1:0][WIDTH-1:0] din;
    logic                         in_xfer;
    logic                         out_xfer;

    assign out_valid = valid[STAGES-1] & ~flush;
    assign out_data  = data[STAGES-1];
    assign out_xfer  = out_valid & out_ready;
    assign in_ready  = ~flush & cap[0];
    assign in_xfer   = in_valid & in_ready;

    // Walk from the output side: a stage has room if it, or any stage after
    // it, is empty, or if the whole chain drains through an output transfer.
    // A running accumulator keeps this free of a vector self-dependency.
    always_comb begin
        logic acc;
        acc = out_ready & ~flush;
        cap = '0;
        for (int k = STAGES-1; k >= 0; k--) begin
            acc    = acc | ~valid[k];
            cap[k] = acc;
        end
    end

    always_comb begin
        vin    = '0;
        din    = '0;
        vin[0] = in_xfer;
        din[0] = in_data;
        for (int k = 1; k < STAGES; k++) begin
            vin[k] = valid[k-1];
            din[k] = data[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
            data  <= {STAGES{RST_VAL}};
            count <= '0;
        end else if (flush) begin
            valid <= '0;
            data  <= {STAGES{RST_VAL}};
            count <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (cap[k]) begin
                    valid[k] <= vin[k];
                    // Empty incoming slot leaves the old data in place.
                    if (vin[k])
                        data[k] <= din[k];
                end
            end
            // The handshake keeps count inside 0..STAGES, so no saturation.
            count <= count + CW'(in_xfer) - CW'(out_xfer);
        end
    end

endmodule

// File: tb/tb_pipe_reg_hs.sv
// -----------------------------------------------------------------------------
// tb_pipe_reg_hs -- directed bench for pipe_reg_hs (WIDTH=8, STAGES=2)
//
// A table of per-cycle records gives the inputs for each cycle and the outputs
// expected just before the next rising edge. Inputs change on the falling edge
// and outputs are sampled 1 time unit later. A short queue-based sequence then
// checks ordering and count under an irregular out_ready pattern.
// -----------------------------------------------------------------------------
module tb_pipe_reg_hs;

    localparam int WIDTH  = 8;
    localparam int STAGES = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       count;

    int checks = 0;
    int errors = 0;

    pipe_reg_hs #(.WIDTH(WIDTH), .STAGES(STAGES), .RST_VAL(8'h00)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       chk;
        logic       rst;
        logic       fl;
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic       e_irdy;
        logic       e_ovld;
        logic [7:0] e_od;
        logic [1:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int row, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", name, row, act, exp);
        end
    endtask

    function automatic vec_t v(input logic chk, input logic rst, input logic fl, input logic iv,
                               input logic [7:0] id, input logic ordy, input logic e_irdy,
                               input logic e_ovld, input logic [7:0] e_od, input logic [1:0] e_cnt);
        vec_t r;
        r.chk = chk; r.rst = rst; r.fl = fl; r.iv = iv; r.id = id; r.ordy = ordy;
        r.e_irdy = e_irdy; r.e_ovld = e_ovld; r.e_od = e_od; r.e_cnt = e_cnt;
        return r;
    endfunction

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        //               chk rst fl iv  id     ordy | irdy ovld od     cnt
        vecs.push_back(v(0, 1, 0, 0, 8'h00, 1,   0, 0, 8'h00, 0)); // 0 reset
        vecs.push_back(v(1, 0, 0, 0, 8'h00, 1,   1, 0, 8'h00, 0)); // 1 reset state
        // streaming 11,22,33 with out_ready=1: first out two cycles later
        vecs.push_back(v(1, 0, 0, 1, 8'h11, 1,   1, 0, 8'h00, 0)); // 2
        vecs.push_back(v(1, 0, 0, 1, 8'h22, 1,   1, 0, 8'h00, 1)); // 3
        vecs.push_back(v(1, 0, 0, 1, 8'h33, 1,   1, 1, 8'h11, 2)); // 4
        vecs.push_back(v(1, 0, 0, 0, 8'h00, 1,   1, 1, 8'h22, 2)); // 5
        vecs.push_back(v(1, 0, 0, 0, 8'h00, 1,   1, 1, 8'h33, 1)); // 6
        vecs.push_back(v(1, 0, 0, 0, 8'hEE, 1,   1, 0, 8'h33, 0)); // 7 empty keeps data
        // stall: A1,A2 accepted, A3 blocked, then drained in order
        vecs.push_back(v(1, 0, 0, 1, 8'hA1, 0,   1, 0, 8'h33, 0)); // 8
        vecs.push_back(v(1, 0, 0, 1, 8'hA2, 0,   1, 0, 8'h33, 1)); // 9
        vecs.push_back(v(1, 0, 0, 1, 8'hA3, 0,   0, 1, 8'hA1, 2)); // 10
        vecs.push_back(v(1, 0, 0, 1, 8'hA3, 0,   0, 1, 8'hA1, 2)); // 11 hold
        vecs.push_back(v(1, 0, 0, 1, 8'hA3, 1,   1, 1, 8'hA1, 2)); // 12 in+out at full
        vecs.push_back(v(1, 0, 0, 1, 8'hB1, 1,   1, 1, 8'hA2, 2)); // 13
        vecs.push_back(v(1, 0, 0, 1, 8'hB2, 1,   1, 1, 8'hA3, 2)); // 14
        vecs.push_back(v(1, 0, 0, 0, 8'h00, 1,   1, 1, 8'hB1, 2)); // 15
        vecs.push_back(v(1, 0, 0, 0, 8'h00, 1,   1, 1, 8'hB2, 1)); // 16
        // flush a full pipe
        vecs.push_back(v(1, 0, 0, 1, 8'h55, 0,   1, 0, 8'hB2, 0)); // 17
        vecs.push_back(v(1, 0, 0, 1, 8'h66, 0,   1, 0, 8'hB2, 1)); // 18
        vecs.push_back(v(1, 0, 1, 1, 8'hCC, 1,   0, 0, 8'h55, 2)); // 19 flush cycle
        vecs.push_back(v(1, 0, 0, 0, 8'h00, 1,   1, 0, 8'h00, 0)); // 20
        // reset together with flush on a full pipe, then 77 through
        vecs.push_back(v(1, 0, 0, 1, 8'hC1, 0,   1, 0, 8'h00, 0)); // 21
        vecs.push_back(v(1, 0, 0, 1, 8'hC2, 0,   1, 0, 8'h00, 1)); // 22
        vecs.push_back(v(1, 1, 1, 1, 8'hDD, 1,   0, 0, 8'hC1, 2)); // 23
        vecs.push_back(v(1, 0, 0, 1, 8'h77, 1,   1, 0, 8'h00, 0)); // 24
        vecs.push_back(v(1, 0, 0, 0, 8'h00, 1,   1, 0, 8'h00, 1)); // 25
        vecs.push_back(v(1, 0, 0, 0, 8'h00, 1,   1, 1, 8'h77, 1)); // 26
        vecs.push_back(v(1, 0, 0, 0, 8'h00, 1,   1, 0, 8'h77, 0)); // 27
        // single word collapses forward while stalled
        vecs.push_back(v(1, 0, 0, 1, 8'h99, 0,   1, 0, 8'h77, 0)); // 28
        vecs.push_back(v(1, 0, 0, 0, 8'h00, 0,   1, 0, 8'h77, 1)); // 29
        vecs.push_back(v(1, 0, 0, 0, 8'h00, 0,   1, 1, 8'h99, 1)); // 30
        vecs.push_back(v(1, 0, 0, 0, 8'h00, 0,   1, 1, 8'h99, 1)); // 31
        vecs.push_back(v(1, 0, 0, 0, 8'h00, 1,   1, 1, 8'h99, 1)); // 32
        vecs.push_back(v(1, 0, 0, 0, 8'h00, 1,   1, 0, 8'h99, 0)); // 33
        // reset mid-stream with out_ready=1: nothing completes
        vecs.push_back(v(1, 0, 0, 1, 8'hE1, 1,   1, 0, 8'h99, 0)); // 34
        vecs.push_back(v(1, 0, 0, 1, 8'hE2, 1,   1, 0, 8'h99, 1)); // 35
        vecs.push_back(v(1, 1, 0, 1, 8'hE3, 1,   1, 1, 8'hE1, 2)); // 36
        vecs.push_back(v(1, 0, 0, 0, 8'h00, 1,   1, 0, 8'h00, 0)); // 37

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset = vecs[i].rst; flush = vecs[i].fl; in_valid = vecs[i].iv;
            in_data = vecs[i].id; out_ready = vecs[i].ordy;
            #1;
            if (vecs[i].chk) begin
                check("in_ready",  i, 64'(in_ready),  64'(vecs[i].e_irdy));
                check("out_valid", i, 64'(out_valid), 64'(vecs[i].e_ovld));
                check("out_data",  i, 64'(out_data),  64'(vecs[i].e_od));
                check("count",     i, 64'(count),     64'(vecs[i].e_cnt));
            end
        end

        // Ordering sequence: 12 words against an irregular out_ready pattern.
        begin
            logic [7:0] q[$];
            logic [39:0] rdy_pat;
            int sent;
            int cyc;
            rdy_pat = 40'hF3_A5_6C_19_E7;
            sent = 0;
            cyc = 0;
            reset = 1'b0; flush = 1'b0;
            while ((sent < 12 || q.size() != 0) && cyc < 200) begin
                @(negedge clk);
                in_valid  = (sent < 12) && (cyc % 5 != 3);
                in_data   = 8'h40 + 8'(sent);
                out_ready = rdy_pat[cyc % 40];
                #1;
                check("seq_count", cyc, 64'(count), 64'(q.size()));
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        check("seq_spurious", cyc, 64'(out_data), 64'hFFFF);
                    end else begin
                        check("seq_data", cyc, 64'(out_data), 64'(q[0]));
                        void'(q.pop_front());
                    end
                end
                if (in_valid && in_ready) begin
                    q.push_back(in_data);
                    sent++;
                end
                cyc++;
            end
            if (cyc >= 200) check("seq_timeout", cyc, 64'(q.size()), 64'(0));
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            check("seq_final_valid", cyc, 64'(out_valid), 64'(0));
            check("seq_final_count", cyc, 64'(count), 64'(0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
